// File: rtl/fe_fifo_packer.sv
// ============================================================================
// Module   : fe_fifo_packer
// Purpose  : Formats front-end capture events into 18-bit storage-FIFO words
//            and buffers them in a small queue to ride out short FIFO-full
//            stalls. If an event has to be dropped, a sticky overflow-blocked
//            flag is raised so the capture stage stops.
// Optional : FE_PACKER_STATS_EN - adds a saturating dropped-entry counter on
//            O_drop_count and an internal high-water occupancy register.
//            When the macro is undefined, O_drop_count is tied to 0.
// Ports    : fe_clk              sole clock
//            reset_i             synchronous active-high reset
//            I_flush             clears the queue and the overflow state
//            I_wr                an entry is presented this cycle
//            I_command/I_time/I_data  entry fields
//            O_fifo_din          formatted word to the storage FIFO
//            O_fifo_wr_en        storage FIFO write strobe
//            I_fifo_full         storage FIFO full
//            I_fifo_almost_full  storage FIFO has at most one free slot
//            O_overflow_blocked  sticky drop flag
//            O_pending           internal queue not empty
//            O_drop_count        dropped-entry counter (statistics build)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef FE_FIFO_SHORTTIME_LEN
`define FE_FIFO_SHORTTIME_LEN 3
`endif
`ifndef FE_FIFO_CMD_TIME
`define FE_FIFO_CMD_TIME 2'b11
`endif

module fe_fifo_packer #(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = `FE_FIFO_SHORTTIME_LEN,
  parameter int pQDEPTH                = 4
) (
  input  logic                             fe_clk,
  input  logic                             reset_i,
  input  logic                             I_flush,
  input  logic                             I_wr,
  input  logic [1:0]                       I_command,
  input  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_time,
  input  logic [7:0]                       I_data,
  output logic [pTIMESTAMP_FULL_WIDTH+1:0] O_fifo_din,
  output logic                             O_fifo_wr_en,
  input  logic                             I_fifo_full,
  input  logic                             I_fifo_almost_full,
  output logic                             O_overflow_blocked,
  output logic                             O_pending,
  output logic [15:0]                      O_drop_count
);

  localparam int c_W   = pTIMESTAMP_FULL_WIDTH + 2;
  localparam int c_AW  = $clog2(pQDEPTH);
  localparam int c_PAD = pTIMESTAMP_FULL_WIDTH - pTIMESTAMP_SHORT_WIDTH - 8;

  typedef enum logic [0:0] {
    pS_RUN     = 1'b0,
    pS_BLOCKED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [c_AW:0]          wr_ptr_q, wr_ptr_d;
  logic [c_AW:0]          rd_ptr_q, rd_ptr_d;
  logic [c_W-1:0]         din_q, din_d;
  logic                   wr_en_q, wr_en_d;
  logic                   pending_q, pending_d;
  logic [c_W-1:0]         mem_q [pQDEPTH];

  logic [pTIMESTAMP_SHORT_WIDTH-1:0] w_tshort;
  logic [c_W-1:0]         w_word;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop_raw;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [c_AW:0]          w_occ_next;

  // Word formatting; the short time field saturates once the timestamp no
  // longer fits in it.
  always_comb begin
    w_tshort = I_time[pTIMESTAMP_SHORT_WIDTH-1:0];
    if (|(I_time >> pTIMESTAMP_SHORT_WIDTH)) begin
      w_tshort = '1;
    end
    if (I_command == `FE_FIFO_CMD_TIME) begin
      w_word = {I_command, I_time};
    end else begin
      w_word = {I_command, w_tshort, {c_PAD{1'b0}}, I_data};
    end
  end

  // Queue control. The wrap bit in each pointer separates full from empty.
  always_comb begin
    w_empty   = (wr_ptr_q == rd_ptr_q);
    w_full    = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
    // Hold off one cycle after a write when the FIFO has only one slot left,
    // since that write may be the one that fills it.
    w_pop_raw = !w_empty && !I_fifo_full && !(wr_en_q && I_fifo_almost_full);
    w_pop     = w_pop_raw && !I_flush;
    w_push    = I_wr && !I_flush && (state_q == pS_RUN) && (!w_full || w_pop_raw);
    w_drop    = I_wr && !I_flush && !w_push;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    din_d     = din_q;
    wr_en_d   = 1'b0;
    state_d   = state_q;
    if (I_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = pS_RUN;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        din_d    = mem_q[rd_ptr_q[c_AW-1:0]];
        wr_en_d  = 1'b1;
      end
      if (w_drop) begin
        state_d = pS_BLOCKED;
      end
    end
    w_occ_next = wr_ptr_d - rd_ptr_d;
    pending_d  = (w_occ_next != '0);
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q   <= pS_RUN;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      din_q     <= '0;
      wr_en_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      din_q     <= din_d;
      wr_en_q   <= wr_en_d;
      pending_q <= pending_d;
    end
  end

  // Queue storage needs no reset: an entry is only read after being written.
  always_ff @(posedge fe_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[c_AW-1:0]] <= w_word;
    end
  end

`ifdef FE_PACKER_STATS_EN
  logic [15:0]   drop_count_q, drop_count_d;
  logic [c_AW:0] hiwater_q, hiwater_d;

  always_comb begin
    drop_count_d = drop_count_q;
    hiwater_d    = hiwater_q;
    if (I_flush) begin
      drop_count_d = '0;
      hiwater_d    = '0;
    end else begin
      if (w_drop && (drop_count_q != 16'hFFFF)) begin
        drop_count_d = drop_count_q + 16'd1;
      end
      if (w_occ_next > hiwater_q) begin
        hiwater_d = w_occ_next;
      end
    end
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      drop_count_q <= '0;
      hiwater_q    <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      hiwater_q    <= hiwater_d;
    end
  end

  assign O_drop_count = drop_count_q;
`else
  assign O_drop_count = 16'd0;
`endif

  assign O_fifo_din         = din_q;
  assign O_fifo_wr_en       = wr_en_q;
  assign O_overflow_blocked = (state_q == pS_BLOCKED);
  assign O_pending          = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_fe_fifo_packer.sv
// ============================================================================
// Module   : tb_fe_fifo_packer
// Purpose  : Self-checking bench for fe_fifo_packer. Expected words are
//            queued as stimulus is issued; a monitor pops and compares on
//            every storage-FIFO write.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef FE_FIFO_CMD_TIME
`define FE_FIFO_CMD_TIME 2'b11
`endif

module tb_fe_fifo_packer;

  logic        fe_clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        I_flush = 1'b0;
  logic        I_wr = 1'b0;
  logic [1:0]  I_command = 2'd0;
  logic [15:0] I_time = 16'd0;
  logic [7:0]  I_data = 8'd0;
  logic        I_fifo_full = 1'b0;
  logic        I_fifo_almost_full = 1'b0;
  logic [17:0] O_fifo_din;
  logic        O_fifo_wr_en;
  logic        O_overflow_blocked;
  logic        O_pending;
  logic [15:0] O_drop_count;

  fe_fifo_packer dut (
    .fe_clk             (fe_clk),
    .reset_i            (reset_i),
    .I_flush            (I_flush),
    .I_wr               (I_wr),
    .I_command          (I_command),
    .I_time             (I_time),
    .I_data             (I_data),
    .O_fifo_din         (O_fifo_din),
    .O_fifo_wr_en       (O_fifo_wr_en),
    .I_fifo_full        (I_fifo_full),
    .I_fifo_almost_full (I_fifo_almost_full),
    .O_overflow_blocked (O_overflow_blocked),
    .O_pending          (O_pending),
    .O_drop_count       (O_drop_count)
  );

  always #5 fe_clk = ~fe_clk;

`ifdef FE_PACKER_STATS_EN
  localparam logic [15:0] c_EXP_DROPS = 16'd2;
`else
  localparam logic [15:0] c_EXP_DROPS = 16'd0;
`endif

  logic [17:0] exp_q [$];
  int          checks   = 0;
  int          passes   = 0;
  int          wr_count = 0;
  int          base     = 0;
  logic        prev_full = 1'b0;
  logic        prev_afb  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Inputs as seen by the DUT at each edge.
  always @(posedge fe_clk) begin
    prev_full <= I_fifo_full;
    prev_afb  <= O_fifo_wr_en && I_fifo_almost_full;
  end

  // Scoreboard monitor.
  always @(negedge fe_clk) begin
    if (!reset_i && O_fifo_wr_en) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got %0h, expected no write", O_fifo_din);
      end else begin
        chk("fifo_word", 32'(O_fifo_din), 32'(exp_q.pop_front()));
      end
      chk("no_wr_after_full", 32'(prev_full), 32'd0);
      chk("almost_full_gap", 32'(prev_afb), 32'd0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge fe_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] c, input logic [15:0] t, input logic [7:0] d);
    I_wr = 1'b1; I_command = c; I_time = t; I_data = d;
    tick();
    I_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(3);
    @(negedge fe_clk);
    chk("rst_wr_en",   32'(O_fifo_wr_en), 32'd0);
    chk("rst_din",     32'(O_fifo_din), 32'd0);
    chk("rst_ovf",     32'(O_overflow_blocked), 32'd0);
    chk("rst_pending", 32'(O_pending), 32'd0);
    chk("rst_drops",   32'(O_drop_count), 32'd0);
    tick();
    reset_i = 1'b0;
    tick(2);

    // Single DATA entry, two-cycle latency
    exp_q.push_back({2'd1, 3'd5, 5'd0, 8'hA5});
    wr(2'd1, 16'd5, 8'hA5);
    @(negedge fe_clk);
    chk("lat_edge_k", 32'(O_fifo_wr_en), 32'd0);
    tick();
    @(negedge fe_clk);
    chk("lat_edge_k1", 32'(O_fifo_wr_en), 32'd1);
    tick(3);

    // TIME entry and short-time saturation boundaries, back to back
    exp_q.push_back({`FE_FIFO_CMD_TIME, 16'h1234});
    exp_q.push_back({2'd2, 3'b111, 5'd0, 8'h3C});
    exp_q.push_back({2'd0, 3'd7, 5'd0, 8'h11});
    exp_q.push_back({2'd1, 3'b111, 5'd0, 8'h22});
    wr(`FE_FIFO_CMD_TIME, 16'h1234, 8'hFF);
    wr(2'd2, 16'd20, 8'h3C);
    wr(2'd0, 16'd7, 8'h11);
    wr(2'd1, 16'd8, 8'h22);
    tick(6);

    // Fill the queue while the FIFO is full, then drain
    I_fifo_full = 1'b1;
    base = wr_count;
    exp_q.push_back({2'd1, 3'd0, 5'd0, 8'h01});
    exp_q.push_back({2'd1, 3'd0, 5'd0, 8'h02});
    exp_q.push_back({2'd1, 3'd0, 5'd0, 8'h03});
    exp_q.push_back({2'd1, 3'd0, 5'd0, 8'h04});
    wr(2'd1, 16'd0, 8'h01);
    wr(2'd1, 16'd0, 8'h02);
    wr(2'd1, 16'd0, 8'h03);
    wr(2'd1, 16'd0, 8'h04);
    tick(2);
    @(negedge fe_clk);
    chk("held_pending", 32'(O_pending), 32'd1);
    chk("held_writes", 32'(wr_count - base), 32'd0);
    chk("held_ovf", 32'(O_overflow_blocked), 32'd0);
    tick();
    I_fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge fe_clk);
      @(negedge fe_clk);
      chk("drain_wr_en", 32'(O_fifo_wr_en), 32'd1);
    end
    chk("drain_pending", 32'(O_pending), 32'd0);
    @(posedge fe_clk);
    @(negedge fe_clk);
    chk("drain_done", 32'(O_fifo_wr_en), 32'd0);
    tick(2);

    // Overflow: six entries into a four-deep queue
    I_fifo_full = 1'b1;
    exp_q.push_back({2'd2, 3'd1, 5'd0, 8'hB0});
    exp_q.push_back({2'd2, 3'd1, 5'd0, 8'hB1});
    exp_q.push_back({2'd2, 3'd1, 5'd0, 8'hB2});
    exp_q.push_back({2'd2, 3'd1, 5'd0, 8'hB3});
    wr(2'd2, 16'd1, 8'hB0);
    wr(2'd2, 16'd1, 8'hB1);
    wr(2'd2, 16'd1, 8'hB2);
    wr(2'd2, 16'd1, 8'hB3);
    @(negedge fe_clk);
    chk("ovf_before_drop", 32'(O_overflow_blocked), 32'd0);
    wr(2'd2, 16'd1, 8'hB4);
    @(negedge fe_clk);
    chk("ovf_after_5th", 32'(O_overflow_blocked), 32'd1);
    wr(2'd2, 16'd1, 8'hB5);
    @(negedge fe_clk);
    chk("drop_count", 32'(O_drop_count), 32'(c_EXP_DROPS));
    tick();
    base = wr_count;
    I_fifo_full = 1'b0;
    tick(8);
    chk("ovf_drain_writes", 32'(wr_count - base), 32'd4);
    chk("ovf_sticky", 32'(O_overflow_blocked), 32'd1);

    // Flush, then rebuild a three-deep queue with the block flag set
    I_flush = 1'b1;
    tick();
    I_flush = 1'b0;
    @(negedge fe_clk);
    chk("flush_clears_ovf", 32'(O_overflow_blocked), 32'd0);
    I_fifo_full = 1'b1;
    exp_q.push_back({2'd1, 3'd2, 5'd0, 8'hC0});
    wr(2'd1, 16'd2, 8'hC0);
    wr(2'd1, 16'd2, 8'hC1);
    wr(2'd1, 16'd2, 8'hC2);
    wr(2'd1, 16'd2, 8'hC3);
    wr(2'd1, 16'd2, 8'hC4);
    @(negedge fe_clk);
    chk("ovf_set_again", 32'(O_overflow_blocked), 32'd1);
    I_fifo_full = 1'b0;
    tick();
    I_fifo_full = 1'b1;
    @(negedge fe_clk);
    chk("one_pop_wr_en", 32'(O_fifo_wr_en), 32'd1);
    chk("three_deep_pending", 32'(O_pending), 32'd1);
    I_flush = 1'b1;
    I_wr = 1'b1; I_command = 2'd1; I_time = 16'd3; I_data = 8'hEE;
    tick();
    I_flush = 1'b0;
    I_wr = 1'b0;
    @(negedge fe_clk);
    chk("flush_pending", 32'(O_pending), 32'd0);
    chk("flush_ovf", 32'(O_overflow_blocked), 32'd0);
    chk("flush_wr_en", 32'(O_fifo_wr_en), 32'd0);
    chk("flush_drops", 32'(O_drop_count), 32'd0);
    base = wr_count;
    I_fifo_full = 1'b0;
    tick(8);
    chk("flush_no_writes", 32'(wr_count - base), 32'd0);

    // Almost-full pacing with a burst of three
    I_fifo_almost_full = 1'b1;
    base = wr_count;
    exp_q.push_back({`FE_FIFO_CMD_TIME, 16'hBEEF});
    exp_q.push_back({2'd2, 3'd6, 5'd0, 8'h5A});
    exp_q.push_back({2'd0, 3'b111, 5'd0, 8'hC3});
    wr(`FE_FIFO_CMD_TIME, 16'hBEEF, 8'h00);
    wr(2'd2, 16'd6, 8'h5A);
    wr(2'd0, 16'hFFFF, 8'hC3);
    tick(10);
    chk("af_writes", 32'(wr_count - base), 32'd3);
    I_fifo_almost_full = 1'b0;
    tick(2);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fe_fifo_packer.md
Name: fe_fifo_packer

Overview:
- Sits directly downstream of the front-end capture stage and upstream of the front-end storage FIFO.
- Takes per-event command, timestamp and data-byte strobes and formats each one into an 18-bit FIFO word.
- Absorbs short full-flag stalls with a small internal queue. On loss it raises a sticky overflow-blocked flag, which feeds back to the capture stage to stop capturing.

Parameters:
- pTIMESTAMP_FULL_WIDTH, 16, width of the timestamp input and of the TIME word payload.
- pTIMESTAMP_SHORT_WIDTH, 3, width of the short time field in DATA words; equals `FE_FIFO_SHORTTIME_LEN.
- pQDEPTH, 4, internal queue depth in entries; must be a power of 2, at least 2.

Ports:
- fe_clk  in  1  front-end clock; sole clock of the block.
- reset_i  in  1  synchronous, active-high reset.
- I_flush  in  1  synchronous clear of queue and overflow state, in fe_clk domain.
- I_wr  in  1  one entry is presented this cycle.
- I_command  in  2  entry command; `FE_FIFO_CMD_TIME marks a time-only entry.
- I_time  in  16  timestamp paired with the entry.
- I_data  in  8  data byte paired with the entry; ignored for TIME entries.
- O_fifo_din  out  18  formatted word to the storage FIFO.
- O_fifo_wr_en  out  1  write strobe to the storage FIFO.
- I_fifo_full  in  1  storage FIFO full.
- I_fifo_almost_full  in  1  storage FIFO has at most one free slot.
- O_overflow_blocked  out  1  sticky; an entry was dropped since the last flush or reset.
- O_pending  out  1  internal queue not empty.
- O_drop_count  out  16  dropped-entry counter; statistics build only.

Behaviour:
- Reset (reset_i = 1): queue empty, O_fifo_wr_en = 0, O_fifo_din = 0, O_overflow_blocked = 0, O_pending = 0, O_drop_count = 0, FSM in pS_RUN.

Word format (formed at push time):
- TIME entry: {cmd, I_time[15:0]}.
- Any other command: {cmd, tshort[2:0], 5'b0, I_data[7:0]}.
- tshort = I_time[2:0] when I_time < 8; otherwise tshort saturates to 3'b111.

Push:
- An I_wr sampled at an edge is stored in the queue at that edge.
- Condition: FSM is in pS_RUN and either the queue is not full or a pop happens at the same edge.

Pop:
- pop = queue non-empty AND !I_fifo_full AND !(O_fifo_wr_en AND I_fifo_almost_full).
- On pop, the head word loads into O_fifo_din and O_fifo_wr_en = 1 for exactly one cycle.
- Otherwise O_fifo_wr_en = 0 and O_fifo_din holds its previous value.

Latency and ordering:
- With the queue empty and the FIFO not full, I_wr at edge k produces O_fifo_wr_en high for the cycle after edge k+1 (2 cycles).
- Sustained throughput is 1 entry per cycle.
- Order is strictly FIFO.

Simultaneous push and pop with the queue full: both occur, and occupancy is unchanged.

Overflow FSM:
- pS_RUN -> pS_BLOCKED when I_wr = 1, the queue is full and there is no pop; that entry is dropped.
- In pS_BLOCKED every I_wr is dropped, but queued entries continue to drain normally.
- pS_BLOCKED -> pS_RUN only on I_flush or reset.
- O_overflow_blocked = (state == pS_BLOCKED), registered.

Flush:
- I_flush empties the queue, forces O_fifo_wr_en = 0 on the next cycle and returns the FSM to pS_RUN.
- I_flush has priority over I_wr and over pop in the same cycle; both are discarded.

Queue pointers wrap modulo pQDEPTH. An extra wrap bit distinguishes full from empty.

O_pending is registered and equals (occupancy != 0).

Optional Feature:
- Macro: FE_PACKER_STATS_EN.
- When defined:
  - O_drop_count increments by 1 on every dropped I_wr, saturating at 16'hFFFF.
  - It clears on I_flush or reset.
  - A high-water occupancy register is kept internally for debug; it is cleared the same way.
- When not defined:
  - O_drop_count is tied to 0.
  - No counter or high-water logic is synthesized.
  - All other behaviour is identical.

Test Plan:
- Single DATA entry (I_command=2'd1, I_time=5, I_data=8'hA5), FIFO not full -> O_fifo_wr_en high 2 cycles later with O_fifo_din = {2'd1, 3'd5, 5'b0, 8'hA5}.
- TIME entry with I_time=16'h1234 -> O_fifo_din = {`FE_FIFO_CMD_TIME, 16'h1234}. DATA entry with I_time=20 -> tshort = 3'b111.
- Hold I_fifo_full=1 and push 4 entries -> no writes, O_pending=1. Release full -> 4 writes on consecutive cycles in order, then O_pending=0.
- Hold I_fifo_full=1 and push 6 entries -> O_overflow_blocked=1 after the 5th; stats build gives O_drop_count=2. Release full -> exactly 4 words written.
- I_flush asserted in the same cycle as I_wr with a 3-deep queue and O_overflow_blocked=1 -> next cycle O_pending=0, O_overflow_blocked=0, O_fifo_wr_en=0, and no word from that I_wr is ever written.
- I_fifo_almost_full=1 with a burst of 3 entries -> at most one write while almost_full is seen with wr_en active; no write ever occurs while I_fifo_full=1.
